// File: rtl/muldiv_if.sv
// Request/result bundle between the execute stage and the HI/LO mul/div sequencer.
interface muldiv_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_zero;

  modport master (
    output start, op, a, b, cancel,
    input  stall, busy, done, hi, lo, div_zero
  );

  modport slave (
    input  start, op, a, b, cancel,
    output stall, busy, done, hi, lo, div_zero
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// Iterative HI/LO multiply/divide sequencer (MULT, MULTU, DIV, DIVU).
// One shift-add or restoring-divide step per cycle, then a sign-fix cycle.
module muldiv_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic    clk,
  input  logic    rst_n,
  muldiv_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_SIGN, S_DONE} state_e;

  state_e state_q, state_d;

  logic [CW-1:0]      cnt_q;
  logic               op_div_q;
  logic               neg_q;
  logic               asign_q;
  logic               dz_q;
  logic [WIDTH-1:0]   mcand_q;   // multiplicand |a| or divisor |b|
  logic [2*WIDTH-1:0] acc_q;     // {partial product, remaining multiplier}
  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   quo_q;     // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic               accept;
  logic               signed_op;
  logic               div_by_zero;
  logic               last_iter;
  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   rem_next;
  logic [WIDTH-1:0]   quo_next;

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   hi_fix;
  logic [WIDTH-1:0]   lo_fix;

  logic               busy_o;
  logic               done_o;
  logic               stall_o;
  logic               dz_o;

  // Request decode and operand magnitudes
  always_comb begin
    accept      = bus.start & ~bus.cancel & ((state_q == S_IDLE) | (state_q == S_DONE));
    signed_op   = ~bus.op[0];
    div_by_zero = bus.op[1] & (bus.b == '0);
    last_iter   = (cnt_q == CW'(WIDTH - 1));
    a_abs       = (signed_op & bus.a[WIDTH-1]) ? -bus.a : bus.a;
    b_abs       = (signed_op & bus.b[WIDTH-1]) ? -bus.b : bus.b;
  end

  // One multiply step and one restoring-divide step per cycle
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? mcand_q : '0)};
    acc_next = {mul_sum, acc_q[WIDTH-1:1]};
    shifted  = {rem_q, quo_q[WIDTH-1]};
    diff     = shifted - {1'b0, mcand_q};
    // Remainder stays below the divisor, so WIDTH bits always hold it
    rem_next = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    quo_next = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
  end

  // Sign fix applied to the unsigned iteration result
  always_comb begin
    prod_fix = neg_q ? -acc_q : acc_q;
    quo_fix  = neg_q ? -quo_q : quo_q;
    rem_fix  = asign_q ? -rem_q : rem_q;
    hi_fix   = op_div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
    lo_fix   = op_div_q ? quo_fix : prod_fix[WIDTH-1:0];
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic; cancel overrides everything
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) state_d = div_by_zero ? S_DONE : S_CALC;
        else        state_d = S_IDLE;
      end
      S_CALC: begin
        if (bus.cancel)     state_d = S_IDLE;
        else if (last_iter) state_d = S_SIGN;
      end
      S_SIGN: state_d = bus.cancel ? S_IDLE : S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy_o  = (state_q == S_CALC) | (state_q == S_SIGN);
    done_o  = (state_q == S_DONE);
    stall_o = accept | busy_o;
    dz_o    = done_o & dz_q;
  end

  assign bus.busy     = busy_o;
  assign bus.done     = done_o;
  assign bus.stall    = stall_o;
  assign bus.div_zero = dz_o;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

  // Operand latch, iteration datapath and HI/LO result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      op_div_q <= 1'b0;
      neg_q    <= 1'b0;
      asign_q  <= 1'b0;
      dz_q     <= 1'b0;
      mcand_q  <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else if (accept) begin
      cnt_q    <= '0;
      op_div_q <= bus.op[1];
      neg_q    <= signed_op & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
      asign_q  <= signed_op & bus.a[WIDTH-1];
      dz_q     <= div_by_zero;
      mcand_q  <= bus.op[1] ? b_abs : a_abs;
      acc_q    <= {{WIDTH{1'b0}}, b_abs};
      rem_q    <= '0;
      quo_q    <= a_abs;
      if (div_by_zero) begin
        hi_q <= bus.a;
        lo_q <= '1;
      end
    end else if (state_q == S_CALC) begin
      cnt_q <= cnt_q + 1'b1;
      acc_q <= acc_next;
      rem_q <= rem_next;
      quo_q <= quo_next;
    end else if ((state_q == S_SIGN) && !bus.cancel) begin
      hi_q <= hi_fix;
      lo_q <= lo_fix;
    end
  end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed self-checking bench for muldiv_ctrl.
module tb_muldiv_ctrl;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;

  muldiv_if #(.WIDTH(32)) mif ();

  muldiv_ctrl #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (mif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called 1ns after a rising edge (accept cycle N); returns in cycle N+1.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic st);
    mif.start = 1'b1; mif.op = op; mif.a = a; mif.b = b;
    #1 st = mif.stall;
    @(posedge clk); #1;
    mif.start = 1'b0;
  endtask

  // Counts edges until done (bounded) and busy cycles seen on the way.
  task automatic wait_done(output int lat, output int bcnt);
    lat = 0; bcnt = 0;
    while (!mif.done && lat < 100) begin
      if (mif.busy) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    mif.start = 1'b0; mif.cancel = 1'b0; mif.op = 2'b00; mif.a = '0; mif.b = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({mif.stall, mif.busy, mif.done, mif.div_zero} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 0000", {mif.stall, mif.busy, mif.done, mif.div_zero});
    end
    n_cmp++;
    if ({mif.hi, mif.lo} !== 64'h0) begin
      n_fail++; $display("FAIL reset_hilo: got %h expected 0", {mif.hi, mif.lo});
    end
  endtask

  task automatic test_multu;
    logic st; int lat; int bcnt;
    issue(2'b01, 32'hFFFFFFFF, 32'h2, st);
    n_cmp++;
    if (st !== 1'b1) begin n_fail++; $display("FAIL multu_stall_accept: got %b expected 1", st); end
    // start while busy must be ignored (would be a divide-by-zero if taken)
    mif.start = 1'b1; mif.op = 2'b11; mif.a = 32'h5; mif.b = 32'h0;
    repeat (3) @(posedge clk);
    #1 mif.start = 1'b0;
    wait_done(lat, bcnt);
    n_cmp++;
    if (lat + 3 !== 33) begin n_fail++; $display("FAIL multu_latency: got %0d expected 33", lat + 3); end
    n_cmp++;
    if (bcnt + 3 !== 33) begin n_fail++; $display("FAIL multu_busy_cycles: got %0d expected 33", bcnt + 3); end
    n_cmp++;
    if ({mif.hi, mif.lo, mif.div_zero} !== {32'h00000001, 32'hFFFFFFFE, 1'b0}) begin
      n_fail++; $display("FAIL multu_result: got hi=%h lo=%h dz=%b expected 00000001 fffffffe 0", mif.hi, mif.lo, mif.div_zero);
    end
    n_cmp++;
    if (mif.stall !== 1'b0) begin n_fail++; $display("FAIL multu_stall_done: got %b expected 0", mif.stall); end
    @(posedge clk); #1;
    n_cmp++;
    if ({mif.done, mif.busy} !== 2'b00) begin
      n_fail++; $display("FAIL multu_pulse: got done/busy=%b expected 00", {mif.done, mif.busy});
    end
  endtask

  task automatic test_signed;
    logic st; int lat; int bcnt;
    issue(2'b00, 32'hFFFFFFFD, 32'h5, st);
    wait_done(lat, bcnt);
    n_cmp++;
    if ({mif.hi, mif.lo} !== {32'hFFFFFFFF, 32'hFFFFFFF1}) begin
      n_fail++; $display("FAIL mult_neg: got hi=%h lo=%h expected ffffffff fffffff1", mif.hi, mif.lo);
    end
    @(posedge clk); #1;
    issue(2'b10, 32'hFFFFFFF9, 32'h2, st);
    wait_done(lat, bcnt);
    n_cmp++;
    if ({mif.hi, mif.lo, mif.div_zero} !== {32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0}) begin
      n_fail++; $display("FAIL div_neg: got hi=%h lo=%h dz=%b expected ffffffff fffffffd 0", mif.hi, mif.lo, mif.div_zero);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    logic st; int lat; int bcnt;
    issue(2'b11, 32'd100, 32'd7, st);
    wait_done(lat, bcnt);
    n_cmp++;
    if ({mif.hi, mif.lo, mif.div_zero} !== {32'd2, 32'd14, 1'b0}) begin
      n_fail++; $display("FAIL divu_result: got hi=%h lo=%h dz=%b expected 2 e 0", mif.hi, mif.lo, mif.div_zero);
    end
    n_cmp++;
    if (lat !== 33) begin n_fail++; $display("FAIL divu_latency: got %0d expected 33", lat); end
    // new start accepted in the DONE cycle
    issue(2'b11, 32'd5, 32'd0, st);
    n_cmp++;
    if (st !== 1'b1) begin n_fail++; $display("FAIL b2b_stall: got %b expected 1", st); end
    n_cmp++;
    if ({mif.done, mif.hi, mif.lo, mif.div_zero} !== {1'b1, 32'd5, 32'hFFFFFFFF, 1'b1}) begin
      n_fail++; $display("FAIL divzero_result: got done=%b hi=%h lo=%h dz=%b expected 1 5 ffffffff 1",
                         mif.done, mif.hi, mif.lo, mif.div_zero);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({mif.done, mif.div_zero, mif.busy} !== 3'b000) begin
      n_fail++; $display("FAIL divzero_pulse: got %b expected 000", {mif.done, mif.div_zero, mif.busy});
    end
  endtask

  task automatic test_cancel;
    logic st; int lat; int bcnt; int dones;
    // start and cancel together in IDLE: cancel wins
    mif.start = 1'b1; mif.cancel = 1'b1; mif.op = 2'b01; mif.a = 32'h3; mif.b = 32'h3;
    #1;
    n_cmp++;
    if (mif.stall !== 1'b0) begin n_fail++; $display("FAIL cancel_start_stall: got %b expected 0", mif.stall); end
    @(posedge clk); #1;
    mif.start = 1'b0; mif.cancel = 1'b0;
    n_cmp++;
    if (mif.busy !== 1'b0) begin n_fail++; $display("FAIL cancel_start_busy: got %b expected 0", mif.busy); end
    issue(2'b01, 32'h12345678, 32'h9, st);
    repeat (9) @(posedge clk);
    #1 mif.cancel = 1'b1;
    @(posedge clk); #1;
    mif.cancel = 1'b0;
    n_cmp++;
    if ({mif.busy, mif.stall} !== 2'b00) begin
      n_fail++; $display("FAIL cancel_busy: got busy/stall=%b expected 00", {mif.busy, mif.stall});
    end
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (mif.done) dones++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (dones !== 0) begin n_fail++; $display("FAIL cancel_no_done: got %0d dones expected 0", dones); end
    n_cmp++;
    if ({mif.hi, mif.lo} !== {32'd5, 32'hFFFFFFFF}) begin
      n_fail++; $display("FAIL cancel_hold: got hi=%h lo=%h expected 5 ffffffff", mif.hi, mif.lo);
    end
    issue(2'b11, 32'd9, 32'd3, st);
    wait_done(lat, bcnt);
    n_cmp++;
    if ({mif.hi, mif.lo} !== {32'd0, 32'd3}) begin
      n_fail++; $display("FAIL after_cancel_divu: got hi=%h lo=%h expected 0 3", mif.hi, mif.lo);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    logic st; int dones; int busies;
    issue(2'b10, 32'd100, 32'd7, st);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({mif.stall, mif.busy, mif.done, mif.div_zero, mif.hi, mif.lo} !== 68'h0) begin
      n_fail++; $display("FAIL reset_mid: got flags=%b hi=%h lo=%h expected all 0",
                         {mif.stall, mif.busy, mif.done, mif.div_zero}, mif.hi, mif.lo);
    end
    @(posedge clk); #3 rst_n = 1'b1;
    dones = 0; busies = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (mif.done) dones++;
      if (mif.busy) busies++;
    end
    n_cmp++;
    if ({dones, busies} !== {32'd0, 32'd0}) begin
      n_fail++; $display("FAIL reset_mid_idle: got dones=%0d busy=%0d expected 0 0", dones, busies);
    end
  endtask

  task automatic test_minint;
    logic st; int lat; int bcnt;
    issue(2'b10, 32'h80000000, 32'hFFFFFFFF, st);
    wait_done(lat, bcnt);
    n_cmp++;
    if ({mif.done, mif.hi, mif.lo, mif.div_zero} !== {1'b1, 32'h0, 32'h80000000, 1'b0}) begin
      n_fail++; $display("FAIL minint_div: got done=%b hi=%h lo=%h dz=%b expected 1 0 80000000 0",
                         mif.done, mif.hi, mif.lo, mif.div_zero);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    test_reset();
    test_multu();
    test_signed();
    test_back_to_back();
    test_cancel();
    test_reset_mid();
    test_minint();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
